// File: rtl/zigzag_buf_if.sv
// zigzag_buf_if: raster-in / zig-zag-out coefficient stream bundle for zigzag_buf.
interface zigzag_buf_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             dout_ready;
    logic             dout_sob;
    logic             dout_eob;
    logic             overflow;

    modport master (
        output din, din_valid, dout_ready,
        input  dout, dout_valid, dout_sob, dout_eob, overflow
    );

    modport slave (
        input  din, din_valid, dout_ready,
        output dout, dout_valid, dout_sob, dout_eob, overflow
    );
endinterface

// File: rtl/zigzag_buf.sv
// zigzag_buf: ping-pong 8x8 block buffer that re-emits raster-order coefficients in JPEG zig-zag order.
module zigzag_buf #(
    parameter int WIDTH = 8
) (
    input logic         clk,
    input logic         nrst,
    zigzag_buf_if.slave bus
);
    localparam int ZZ [64] = '{
         0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
        12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
        35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
        58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
    };

    logic [WIDTH-1:0] mem [2][64];

    logic [1:0]       full_q, full_d;
    logic [5:0]       wr_idx_q, wr_idx_d;
    logic [5:0]       rd_idx_q, rd_idx_d;
    logic             wr_bank_q, wr_bank_d;
    logic             rd_bank_q, rd_bank_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             dout_valid_q, dout_valid_d;
    logic             sob_q, sob_d;
    logic             eob_q, eob_d;
    logic             overflow_q, overflow_d;

    logic             wr_en, rd_en, wr_last, rd_last;
    logic [5:0]       zz_addr;

    always_comb begin
        wr_en        = bus.din_valid && !full_q[wr_bank_q];
        rd_en        = full_q[rd_bank_q] && (!dout_valid_q || bus.dout_ready);
        wr_last      = wr_idx_q == 6'd63;
        rd_last      = rd_idx_q == 6'd63;
        zz_addr      = 6'(ZZ[rd_idx_q]);
        // a bank freed by the read side is only writable from the following cycle
        full_d       = full_q;
        if (rd_en && rd_last) full_d[rd_bank_q] = 1'b0;
        if (wr_en && wr_last) full_d[wr_bank_q] = 1'b1;
        wr_idx_d     = wr_en ? wr_idx_q + 6'd1 : wr_idx_q;
        wr_bank_d    = wr_bank_q ^ (wr_en && wr_last);
        rd_idx_d     = rd_en ? rd_idx_q + 6'd1 : rd_idx_q;
        rd_bank_d    = rd_bank_q ^ (rd_en && rd_last);
        dout_d       = rd_en ? mem[rd_bank_q][zz_addr] : dout_q;
        sob_d        = rd_en ? rd_idx_q == 6'd0 : sob_q;
        eob_d        = rd_en ? rd_last : eob_q;
        dout_valid_d = rd_en || (dout_valid_q && !bus.dout_ready);
        overflow_d   = overflow_q || (bus.din_valid && full_q[wr_bank_q]);
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_bank_q][wr_idx_q] <= bus.din;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            full_q       <= 2'b00;
            wr_idx_q     <= 6'd0;
            rd_idx_q     <= 6'd0;
            wr_bank_q    <= 1'b0;
            rd_bank_q    <= 1'b0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            sob_q        <= 1'b0;
            eob_q        <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            full_q       <= full_d;
            wr_idx_q     <= wr_idx_d;
            rd_idx_q     <= rd_idx_d;
            wr_bank_q    <= wr_bank_d;
            rd_bank_q    <= rd_bank_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            sob_q        <= sob_d;
            eob_q        <= eob_d;
            overflow_q   <= overflow_d;
        end
    end

    assign bus.dout       = dout_q;
    assign bus.dout_valid = dout_valid_q;
    assign bus.dout_sob   = sob_q;
    assign bus.dout_eob   = eob_q;
    assign bus.overflow   = overflow_q;
endmodule

// File: tb/tb_zigzag_buf.sv
// tb_zigzag_buf: scoreboard bench for zigzag_buf; zig-zag order is rebuilt here by diagonal walk.
module tb_zigzag_buf;
    logic clk = 1'b0;
    logic nrst = 1'b1;
    always #5 clk = ~clk;

    zigzag_buf_if #(.WIDTH(8)) bus ();
    zigzag_buf #(.WIDTH(8)) dut (.clk(clk), .nrst(nrst), .bus(bus));

    typedef struct {
        logic [7:0] v;
        logic       sob;
        logic       eob;
    } exp_t;

    typedef struct {
        int n;
        int gap;
        bit ready;
        int pat;
        int acc;
        bit ovf;
        bit contig;
    } vec_t;

    exp_t       sbq [$];
    exp_t       e;
    int         zz [64];
    logic [7:0] src [256];
    int         passed = 0, total = 0, outs = 0, cyc = 0, first_out = -1, last_out = -1;

    task automatic check(input bit ok, input string nm, input int act, input int exp);
        total++;
        if (ok) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    always @(negedge clk) begin
        cyc++;
        if (nrst && bus.dout_valid && bus.dout_ready) begin
            if (first_out < 0) first_out = cyc;
            last_out = cyc;
            outs++;
            if (sbq.size() == 0) check(1'b0, "unexpected_out", int'(bus.dout), 0);
            else begin
                e = sbq.pop_front();
                check({bus.dout_sob, bus.dout_eob, bus.dout} === {e.sob, e.eob, e.v}, "zz_out",
                      int'({bus.dout_sob, bus.dout_eob, bus.dout}), int'({e.sob, e.eob, e.v}));
            end
        end
    end

    task automatic build_zz;
        int k = 0;
        for (int s = 0; s < 15; s++) begin
            if (s % 2 == 0)
                for (int r = (s < 7 ? s : 7); r >= (s > 7 ? s - 7 : 0); r--) begin
                    zz[k] = r * 8 + (s - r);
                    k++;
                end
            else
                for (int r = (s > 7 ? s - 7 : 0); r <= (s < 7 ? s : 7); r++) begin
                    zz[k] = r * 8 + (s - r);
                    k++;
                end
        end
    endtask

    task automatic fill(input int pat);
        for (int i = 0; i < 256; i++)
            src[i] = pat == 0 ? 8'(i) : pat == 1 ? 8'($urandom) : (i % 64 == 63 ? 8'h7F : 8'h80);
    endtask

    // samples before 'skip' are expected to be dropped; every 64th accepted one completes a block
    task automatic feed(input int off, input int n, input int gap, input int skip);
        for (int i = off; i < off + n; i++) begin
            int j;
            j = i - off - skip;
            bus.din = src[i];
            bus.din_valid = 1'b1;
            if (j >= 0 && j % 64 == 63)
                for (int k = 0; k < 64; k++) sbq.push_back('{src[i - 63 + zz[k]], k == 0, k == 63});
            @(posedge clk); #1;
            if (gap > 0) begin
                bus.din_valid = 1'b0;
                repeat (gap) begin @(posedge clk); #1; end
            end
        end
        bus.din_valid = 1'b0;
    endtask

    task automatic drain(input int acc, input bit ovf, input bit contig);
        int n = 0;
        while (sbq.size() != 0 && n < 600) begin
            @(posedge clk); #1;
            n++;
        end
        repeat (4) begin @(posedge clk); #1; end
        check(sbq.size() == 0, "drain_left", sbq.size(), 0);
        check(outs == acc, "out_count", outs, acc);
        check(bus.overflow === ovf, "overflow", int'(bus.overflow), int'(ovf));
        check(bus.dout_valid === 1'b0, "idle_valid", int'(bus.dout_valid), 0);
        if (contig) check(last_out - first_out + 1 == acc, "no_bubble", last_out - first_out + 1, acc);
    endtask

    task automatic do_reset;
        @(posedge clk); #3;
        nrst = 1'b0;
        #1;
        check({bus.dout_valid, bus.dout_sob, bus.dout_eob, bus.overflow, bus.dout} === 12'h0, "reset_outs",
              int'({bus.dout_valid, bus.dout_sob, bus.dout_eob, bus.overflow, bus.dout}), 0);
        sbq.delete();
        bus.din_valid = 1'b0;
        outs = 0;
        first_out = -1;
        last_out = -1;
        repeat (2) @(posedge clk);
        @(negedge clk) nrst = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        vec_t tbl [6];
        int   w;
        tbl[0] = '{64, 0, 1'b1, 0, 64, 1'b0, 1'b1};
        tbl[1] = '{128, 0, 1'b1, 0, 128, 1'b0, 1'b1};
        tbl[2] = '{129, 0, 1'b0, 0, 128, 1'b1, 1'b1};
        tbl[3] = '{64, 1, 1'b1, 2, 64, 1'b0, 1'b0};
        tbl[4] = '{192, 0, 1'b1, 1, 192, 1'b0, 1'b1};
        tbl[5] = '{100, 0, 1'b1, 1, 64, 1'b0, 1'b1};
        build_zz();
        bus.din = '0;
        bus.din_valid = 1'b0;
        bus.dout_ready = 1'b1;
        do_reset();

        fill(0);
        feed(0, 64, 0, 0);
        check(bus.dout_valid === 1'b0, "lat_pre", int'(bus.dout_valid), 0);
        @(posedge clk); #1;
        check(bus.dout_valid === 1'b1 && bus.dout === src[0] && bus.dout_sob === 1'b1, "lat_first",
              int'({bus.dout_valid, bus.dout_sob, bus.dout}), int'({2'b11, src[0]}));
        drain(64, 1'b0, 1'b1);

        for (int i = 0; i < 6; i++) begin
            do_reset();
            fill(tbl[i].pat);
            bus.dout_ready = tbl[i].ready;
            feed(0, tbl[i].n, tbl[i].gap, 0);
            if (!tbl[i].ready) begin
                check(bus.overflow === tbl[i].ovf, "ovf_stall", int'(bus.overflow), int'(tbl[i].ovf));
                bus.dout_ready = 1'b1;
            end
            drain(tbl[i].acc, tbl[i].ovf, tbl[i].contig);
        end

        // backpressure while zig-zag index 5 (raster 2) is presented
        do_reset();
        fill(0);
        feed(0, 64, 0, 0);
        w = 0;
        while (!(bus.dout_valid === 1'b1 && bus.dout === 8'd2) && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        check(w < 20, "bp_wait", w, 20);
        bus.dout_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            check({bus.dout_valid, bus.dout_sob, bus.dout_eob, bus.dout} === {3'b100, 8'd2}, "bp_hold",
                  int'({bus.dout_valid, bus.dout_sob, bus.dout_eob, bus.dout}), int'({3'b100, 8'd2}));
        end
        bus.dout_ready = 1'b1;
        drain(64, 1'b0, 1'b0);

        // reset while one block drains and a second is partly written
        do_reset();
        fill(1);
        feed(0, 94, 0, 0);
        check(bus.dout_valid === 1'b1, "pre_rst_valid", int'(bus.dout_valid), 1);
        do_reset();
        fill(1);
        feed(0, 64, 0, 0);
        drain(64, 1'b0, 1'b1);

        // bank cleared and written on the same edge: that write is dropped
        do_reset();
        fill(1);
        for (int i = 128; i < 191; i++) src[i] = 8'hEE;
        bus.dout_ready = 1'b0;
        feed(0, 128, 0, 0);
        check(bus.overflow === 1'b0, "ovf_pre", int'(bus.overflow), 0);
        bus.dout_ready = 1'b1;
        feed(128, 127, 0, 63);
        drain(192, 1'b1, 1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/zigzag_buf.md
Name: zigzag_buf

Overview:
- Sits directly downstream of the forward DCT/quantiser stage.
- Accepts quantised 8x8 coefficient blocks as a raster-order serial stream, one coefficient per valid cycle (row 0 col 0..7, then row 1, ...).
- Re-emits each block in JPEG zig-zag order for the entropy coder, with a ready/valid output handshake.
- Ping-pong buffered so a new block can be written while the previous block drains.

Parameters:
- WIDTH, 8: coefficient width in bits (two's complement, passed through unmodified).

Ports:
- clk  input  1  system clock, rising edge.
- nrst  input  1  asynchronous active-low reset.
- din  input  WIDTH  quantised coefficient, raster order.
- din_valid  input  1  din is valid this cycle. No backpressure toward upstream.
- dout  output  WIDTH  coefficient in zig-zag order.
- dout_valid  output  1  dout is valid.
- dout_ready  input  1  downstream accepts dout this cycle.
- dout_sob  output  1  high with zig-zag index 0 (DC) of a block.
- dout_eob  output  1  high with zig-zag index 63 of a block.
- overflow  output  1  sticky error: an input sample was dropped.

Behaviour:
- Reset (async, nrst low):
  - dout, dout_valid, dout_sob, dout_eob and overflow go to 0 immediately.
  - Both banks marked empty; wr_idx, rd_idx, wr_bank and rd_bank go to 0.
  - Bank memory contents are not reset.
  - Reset mid-block discards all partial and full blocks.
- Storage: two banks of 64 x WIDTH registers, with a full flag per bank.
- Write side:
  - When din_valid=1 and full[wr_bank]=0 (value before the edge), store din at mem[wr_bank][wr_idx] and increment wr_idx.
  - At wr_idx=63: set full[wr_bank], toggle wr_bank, wrap wr_idx to 0.
  - When din_valid=1 and full[wr_bank]=1: drop the sample, leave wr_idx unchanged, set overflow. overflow stays set until reset.
- Read side:
  - Output register loads when full[rd_bank]=1 and (dout_valid=0 or dout_ready=1).
  - Load: dout <= mem[rd_bank][ZZ[rd_idx]]; dout_sob <= (rd_idx==0); dout_eob <= (rd_idx==63); dout_valid <= 1; then rd_idx++.
  - When index 63 is loaded: clear full[rd_bank], toggle rd_bank, wrap rd_idx to 0.
  - When the register cannot load and dout_ready=1: dout_valid <= 0.
  - When dout_valid=1 and dout_ready=0: dout, dout_sob and dout_eob hold stable.
- Simultaneous clear and write on the same bank in one cycle: the clear takes effect at that edge. The write is tested against the pre-edge full value, so it is dropped (overflow). A write to that bank is accepted from the next cycle.
- Latency: with dout_ready=1, dout_valid rises one cycle after the edge that sampled the 64th input.
- Throughput: 1 coefficient/cycle sustained. With continuous input and dout_ready=1 there is no output bubble between blocks and no overflow.
- ZZ table is the standard JPEG zig-zag, mapping output index to raster index:
  0,1,8,16,9,2,3,10,17,24,32,25,18,11,4,5,12,19,26,33,40,48,41,34,27,20,13,6,7,14,21,28,35,42,49,56,57,50,43,36,29,22,15,23,30,37,44,51,58,59,52,45,38,31,39,46,53,60,61,54,47,55,62,63.
- din is a gappy stream: idle cycles inside a block are allowed and do not advance wr_idx.

Test Plan:
1. Single block, din = raster index 0..63 on consecutive cycles, dout_ready=1 -> dout = 0,1,8,16,9,2,3,10,...,62,63; dout_sob only on the 0, dout_eob only on the 63; first dout_valid one cycle after the 64th input; overflow=0.
2. 128 consecutive inputs (block A values 0..63, block B values 64..127), dout_ready=1 -> 128 outputs; B's first output (64) is in the cycle immediately after A's eob beat; overflow=0.
3. Backpressure: dout_ready=0 for 10 cycles while zig-zag index 5 (value 2) is presented -> dout=2, dout_valid=1 and sob/eob stable for all 10 cycles; the sequence resumes with 3 with no loss or duplication.
4. Overflow: dout_ready=0, 129 samples with din_valid=1 -> overflow=1 after the 129th; then dout_ready=1 -> exactly 128 outputs, equal to the first two blocks in zig-zag order.
5. Reset mid-operation: pull nrst low after 30 samples of a block -> all outputs 0 immediately; after release a fresh 64-sample block yields exactly 64 correct outputs with no residue.
6. Signed data with gaps: raster block filled with 8'h80 except raster 63 = 8'h7F, din_valid toggling every other cycle -> 63 outputs of 8'h80, then 8'h7F with eob.
